hc595_shifter: RTL and testbench

HC595_SHIFTER -- requirements
Module: hc595_shifter

---
 rtl/hc595_shifter.sv | 70 +++++++
 tb/tb_hc595_shifter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hc595_shifter.sv
// hc595_shifter: serialises a {seg, sel} frame MSB-first into a 74HC595 chain, then pulses the latch.
module hc595_shifter #(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg,
  input  logic [5:0] sel,
  input  logic       valid,
  output logic       ready,
  output logic       shcp,
  output logic       stcp,
  output logic       ds,
  output logic       oe
);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t state, state_n;
  logic [13:0] frame;
  logic [7:0] div_cnt;
  logic [3:0] bit_idx;
  logic phase, phase_n, accept, div_end, bit_done, next_bit;
  logic shcp_n, stcp_n, ds_n, ready_n, oe_n;
  assign accept = state == IDLE && valid;
  assign div_end = div_cnt == 8'(DIV - 1);
  assign bit_done = state == SHIFT && div_end && phase;
  assign next_bit = bit_done && bit_idx != 4'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      frame <= '0;
      div_cnt <= '0;
      bit_idx <= '0;
      phase <= 1'b0;
      ready <= 1'b1;
      shcp <= 1'b0;
      stcp <= 1'b0;
      ds <= 1'b0;
      oe <= 1'b1;
    end else begin
      state <= state_n;
      frame <= accept ? {seg, sel} : frame;
      div_cnt <= (state == IDLE || div_end) ? 8'd0 : div_cnt + 8'd1;
      bit_idx <= accept ? 4'd13 : next_bit ? bit_idx - 4'd1 : bit_idx;
      phase <= phase_n;
      ready <= ready_n;
      shcp <= shcp_n;
      stcp <= stcp_n;
      ds <= ds_n;
      oe <= oe_n;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = valid ? SHIFT : IDLE;
      SHIFT:   state_n = (bit_done && bit_idx == 4'd0) ? LATCH : SHIFT;
      LATCH:   state_n = div_end ? IDLE : LATCH;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are computed one cycle ahead and registered, so each follows its state with no input-to-output path.
  always_comb begin
    phase_n = accept ? 1'b0 : (state == SHIFT && div_end) ? ~phase : phase;
    ready_n = state_n == IDLE;
    stcp_n = state_n == LATCH;
    shcp_n = state_n == SHIFT && phase_n;
    ds_n = accept ? seg[7] : next_bit ? frame[bit_idx - 4'd1] : (state_n == SHIFT) ? ds : 1'b0;
    oe_n = oe && !(state == LATCH && div_end);
  end
endmodule

// File: tb/tb_hc595_shifter.sv
// tb_hc595_shifter: directed checks of framing, timing, busy handling and reset for DIV=1 and DIV=2.
module tb_hc595_shifter;
  logic clk = 0, rst = 1, valid = 0, dsel = 0;
  logic [7:0] seg = 0;
  logic [5:0] sel = 0;
  logic ready1, shcp1, stcp1, ds1, oe1, ready2, shcp2, stcp2, ds2, oe2;
  logic m_ready, m_shcp, m_stcp, m_ds, m_oe;
  int nchk = 0, nfail = 0;
  always #5 clk = ~clk;
  hc595_shifter #(.DIV(1)) u1 (.clk(clk), .rst(rst), .seg(seg), .sel(sel), .valid(valid & !dsel),
    .ready(ready1), .shcp(shcp1), .stcp(stcp1), .ds(ds1), .oe(oe1));
  hc595_shifter #(.DIV(2)) u2 (.clk(clk), .rst(rst), .seg(seg), .sel(sel), .valid(valid & dsel),
    .ready(ready2), .shcp(shcp2), .stcp(stcp2), .ds(ds2), .oe(oe2));
  assign m_ready = dsel ? ready2 : ready1;
  assign m_shcp = dsel ? shcp2 : shcp1;
  assign m_stcp = dsel ? stcp2 : stcp1;
  assign m_ds = dsel ? ds2 : ds1;
  assign m_oe = dsel ? oe2 : oe1;

  task automatic capture(input int n, input logic [7:0] s, input logic [5:0] l, input int poke_at,
      input logic [7:0] ps, input logic [5:0] pl, input logic pv, output logic [13:0] bits,
      output int nrise, output int nstcp, output int low_cnt, output int first_ready,
      output logic oe_latch, output logic oe_after);
    logic prev;
    prev = 0; bits = 0; nrise = 0; nstcp = 0; low_cnt = 0; first_ready = 0; oe_latch = 1'bx; oe_after = 1'bx;
    seg = s; sel = l; valid = 1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (m_shcp && !prev) begin bits = {bits[12:0], m_ds}; nrise++; end
      prev = m_shcp;
      if (m_stcp) begin nstcp++; oe_latch = m_oe; end
      if (!m_ready) low_cnt++;
      else if (first_ready == 0) begin first_ready = k; oe_after = m_oe; end
      if (k == 1) valid = 0;
      if (k == poke_at) begin seg = ps; sel = pl; valid = pv; end
      else if (k == poke_at + 1) valid = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    nchk++; if ({ready1, shcp1, stcp1, ds1, oe1} !== 5'b10001) begin nfail++; $display("FAIL reset_div1 got %b want 10001", {ready1, shcp1, stcp1, ds1, oe1}); end
    nchk++; if ({ready2, shcp2, stcp2, ds2, oe2} !== 5'b10001) begin nfail++; $display("FAIL reset_div2 got %b want 10001", {ready2, shcp2, stcp2, ds2, oe2}); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [13:0] b; int nr, ns, lc, fr; logic ol, oa;
    dsel = 0;
    capture(35, 8'h91, 6'b000001, 0, 8'h00, 6'b0, 1'b0, b, nr, ns, lc, fr, ol, oa);
    nchk++; if (b !== 14'b10010001000001) begin nfail++; $display("FAIL single_bits got %b want 10010001000001", b); end
    nchk++; if (nr !== 14) begin nfail++; $display("FAIL single_shcp_edges got %0d want 14", nr); end
    nchk++; if (ns !== 1) begin nfail++; $display("FAIL single_stcp_cycles got %0d want 1", ns); end
    nchk++; if (lc !== 29) begin nfail++; $display("FAIL single_busy got %0d want 29", lc); end
    nchk++; if (fr !== 30) begin nfail++; $display("FAIL single_ready_back got %0d want 30", fr); end
    nchk++; if (ol !== 1'b1) begin nfail++; $display("FAIL single_oe_in_latch got %b want 1", ol); end
    nchk++; if (oa !== 1'b0) begin nfail++; $display("FAIL single_oe_after got %b want 0", oa); end
  endtask

  task automatic test_busy_pulse();
    logic [13:0] b; int nr, ns, lc, fr; logic ol, oa;
    dsel = 0;
    capture(35, 8'h5A, 6'b001000, 5, 8'hFF, 6'b111111, 1'b1, b, nr, ns, lc, fr, ol, oa);
    nchk++; if (b !== {8'h5A, 6'b001000}) begin nfail++; $display("FAIL busy_bits got %h want %h", b, {8'h5A, 6'b001000}); end
    nchk++; if (ns !== 1) begin nfail++; $display("FAIL busy_stcp got %0d want 1", ns); end
    nchk++; if (lc !== 29 || fr !== 30) begin nfail++; $display("FAIL busy_ready got low=%0d first=%0d want 29/30", lc, fr); end
  endtask

  task automatic test_capture_hold();
    logic [13:0] b; int nr, ns, lc, fr; logic ol, oa;
    dsel = 0;
    capture(35, 8'hE7, 6'b000100, 1, 8'h00, 6'b111111, 1'b0, b, nr, ns, lc, fr, ol, oa);
    nchk++; if (b !== {8'hE7, 6'b000100}) begin nfail++; $display("FAIL hold_bits got %h want %h", b, {8'hE7, 6'b000100}); end
    nchk++; if (nr !== 14) begin nfail++; $display("FAIL hold_edges got %0d want 14", nr); end
  endtask

  task automatic test_back_to_back();
    logic [41:0] bits; logic prev; int nr, ns, nrdy, acc, ovl; int pos [3];
    bits = 0; prev = 0; nr = 0; ns = 0; nrdy = 0; acc = 1; ovl = 0; pos = '{0, 0, 0};
    dsel = 1; seg = 8'h3C; sel = 6'b100000; valid = 1;
    for (int k = 1; k <= 177; k++) begin
      @(negedge clk);
      if (m_shcp && !prev) begin bits = {bits[40:0], m_ds}; nr++; end
      prev = m_shcp;
      if (m_stcp) ns++;
      if (m_stcp && m_shcp) ovl++;
      if (m_ready) begin
        if (nrdy < 3) pos[nrdy] = k;
        nrdy++;
        if (acc < 3) begin
          {seg, sel} = (acc == 1) ? {8'hC3, 6'b010101} : {8'h3C, 6'b100000};
          acc++;
        end else valid = 0;
      end
    end
    valid = 0;
    nchk++; if (bits !== {8'h3C, 6'b100000, 8'hC3, 6'b010101, 8'h3C, 6'b100000}) begin nfail++; $display("FAIL b2b_bits got %h", bits); end
    nchk++; if (nr !== 42) begin nfail++; $display("FAIL b2b_edges got %0d want 42", nr); end
    nchk++; if (ns !== 6) begin nfail++; $display("FAIL b2b_stcp got %0d want 6", ns); end
    nchk++; if (nrdy !== 3 || pos[0] !== 59 || pos[1] !== 118 || pos[2] !== 177) begin nfail++; $display("FAIL b2b_ready got n=%0d at %0d %0d %0d want 3 at 59 118 177", nrdy, pos[0], pos[1], pos[2]); end
    nchk++; if (ovl !== 0) begin nfail++; $display("FAIL b2b_overlap got %0d want 0", ovl); end
    dsel = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ns, lc;
    ns = 0; lc = 0;
    dsel = 0; seg = 8'hAA; sel = 6'b000010; valid = 1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (stcp1) ns++;
      if (k == 1) valid = 0;
    end
    nchk++; if ({ready1, oe1} !== 2'b00) begin nfail++; $display("FAIL midrst_busy got ready,oe=%b want 00", {ready1, oe1}); end
    rst = 1;
    @(negedge clk);
    nchk++; if ({ready1, shcp1, stcp1, ds1, oe1} !== 5'b10001) begin nfail++; $display("FAIL midrst_state got %b want 10001", {ready1, shcp1, stcp1, ds1, oe1}); end
    rst = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stcp1) ns++;
      if (!ready1) lc++;
    end
    nchk++; if (ns !== 0 || lc !== 0) begin nfail++; $display("FAIL midrst_quiet got stcp=%0d busy=%0d want 0/0", ns, lc); end
  endtask

  task automatic test_reset_valid();
    dsel = 0; seg = 8'h12; sel = 6'b000001; valid = 1; rst = 1;
    @(negedge clk);
    nchk++; if ({ready1, shcp1} !== 2'b10) begin nfail++; $display("FAIL rstvalid_edge got %b want 10", {ready1, shcp1}); end
    rst = 0; valid = 0;
    @(negedge clk);
    nchk++; if (ready1 !== 1'b1) begin nfail++; $display("FAIL rstvalid_after got %b want 1", ready1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_pulse();
    test_capture_hold();
    test_back_to_back();
    test_reset_mid();
    test_reset_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
